// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory combinationally
// and captures the returned word into the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_next,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] LP_DEPTH = 32'(MEM_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fault_state_t;

  fault_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_id_pc;
  logic [31:0]  r_id_pc_next;
  logic         r_valid;

  logic         w_inrange;
  logic [31:0]  w_pc_inc;

  assign w_inrange = (r_pc < LP_DEPTH);
  assign w_pc_inc  = r_pc + 32'd1;

  // Priority: redirect > flush > stall > normal fetch; FAULT state only affects the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_instr      <= 32'd0;
      r_id_pc      <= 32'd0;
      r_id_pc_next <= 32'd0;
      r_valid      <= 1'b0;
    end else if (redirect) begin
      r_pc         <= redirect_pc;
      r_instr      <= 32'd0;
      r_id_pc      <= r_pc;
      r_id_pc_next <= w_pc_inc;
      r_valid      <= 1'b0;
    end else if (flush) begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      if (!stall && w_inrange) begin
        r_pc <= w_pc_inc;
      end
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (w_inrange) begin
      r_instr      <= imem_data;
      r_id_pc      <= r_pc;
      r_id_pc_next <= w_pc_inc;
      r_valid      <= 1'b1;
      r_pc         <= w_pc_inc;
    end else begin
      // Out-of-range fetch: hold the PC until a redirect brings it back.
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_state <= ST_FAULT;
    end
  end

  assign imem_addr     = r_pc;
  assign if_id_instr   = r_instr;
  assign if_id_pc      = r_id_pc;
  assign if_id_pc_next = r_id_pc_next;
  assign if_id_valid   = r_valid;
  assign fetch_fault   = (r_state == ST_FAULT);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of Instruction_Memory.
- Owns the program counter and drives the memory's word-indexed `addr` input combinationally.
- Captures the returned instruction into an IF/ID pipeline register for the decode stage.
- Supports stall, flush and branch/jump redirect from later pipeline stages, and flags fetches beyond the memory depth.

Parameters:
- RESET_PC, 0, word address loaded into PC on reset.
- MEM_DEPTH, 32, number of instruction words in memory; legal PC range is 0..MEM_DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  invalidate IF/ID on this edge.
- redirect  in  1  load PC from redirect_pc; squashes the in-flight fetch.
- redirect_pc  in  32  branch/jump target, word address.
- imem_addr  out  32  to Instruction_Memory addr; equals PC, combinational.
- imem_data  in  32  from Instruction_Memory out; valid in the same cycle.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  registered address of if_id_instr.
- if_id_pc_next  out  32  registered if_id_pc+1, mod 2^32.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky out-of-range fetch flag.

Behaviour:
- Reset (async, takes effect immediately, also mid-operation):
  - PC=RESET_PC, so imem_addr=RESET_PC.
  - if_id_instr=0, if_id_pc=0, if_id_pc_next=0, if_id_valid=0, fetch_fault=0.
- First valid instruction appears in IF/ID on the first rising edge after rst deasserts.
- imem_addr=PC at all times; no extra address latency. Instruction latency: PC presented in cycle N, instruction visible on if_id_* after edge N.
- "inrange" means PC < MEM_DEPTH (unsigned compare).
- Per rising edge, evaluated in priority order; first match applies:
  1. redirect=1:
     - PC<=redirect_pc.
     - if_id_valid<=0, if_id_instr<=0. if_id_pc and if_id_pc_next are don't-care but must be deterministic; load them from PC and PC+1.
     - Overrides stall and flush.
  2. flush=1:
     - if_id_valid<=0, if_id_instr<=0.
     - PC<=PC if stall=1, otherwise PC<=PC+1 when inrange, or held when not inrange.
  3. stall=1: PC and all if_id_* hold.
  4. Normal, inrange:
     - if_id_instr<=imem_data, if_id_pc<=PC, if_id_pc_next<=PC+1, if_id_valid<=1.
     - PC<=PC+1.
  5. Normal, not inrange:
     - PC holds.
     - if_id_valid<=0, if_id_instr<=0.
     - fetch_fault<=1.
- fetch_fault is sticky: it is cleared only by rst. A redirect back into range resumes fetching, but fetch_fault stays 1.
- PC arithmetic is 32-bit modulo; PC+1 at 0xFFFFFFFF wraps to 0. This is unreachable in practice for MEM_DEPTH≤2^32-1, because the fault hold happens first.
- redirect_pc is not range-checked at load time. It is checked when it is fetched, per item 5.
- No combinational path from any input to any output except PC→imem_addr, and that path comes from a register.
- Two-state state machine on fetch_fault: RUN→FAULT on case 5; FAULT→RUN only via rst. PC behaviour is identical in both states; only the flag differs.

Test Plan:
- Sequential fetch: memory words 0..3 = 0x11111111..0x44444444; release rst → over 4 edges if_id_pc=0,1,2,3, if_id_instr matches each word, if_id_pc_next=pc+1, valid=1 each cycle.
- Stall: assert stall for 2 cycles while if_id_pc=2 → imem_addr stays 3, if_id holds pc=2 and its instruction, valid=1; on release, next edge gives pc=3.
- Redirect with simultaneous stall: at PC=5, redirect=1, redirect_pc=0x10, stall=1 → next edge PC=0x10, valid=0; following edge if_id_pc=0x10, valid=1.
- Flush alone: at PC=7, flush=1 → valid=0, PC=8; next edge if_id_pc=8, valid=1.
- Out of range, MEM_DEPTH=32: redirect to 31 → fetch 31 valid, then PC=32 held, valid=0, fetch_fault=1; redirect to 0 → fetching resumes, fault stays 1.
- Async reset mid-run: assert rst between edges at PC=9 → imem_addr=0, valid=0, fetch_fault=0 immediately, with no clock edge required.
